// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: passes CPU accesses to mem while idle and copies one page into OAM on trigger.
// Latency: 2 cycles from trigger edge to first oam_we (3 with ALIGN); 513/514-cycle stall per transfer.
// Backpressure: stalls the CPU through cpu_rdy while busy; a CPU write held during HALT extends HALT.
module oam_dma_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'h4014,
  parameter int XFER_LEN = 256,
  localparam int IDX_W = $clog2(XFER_LEN),
  localparam int PAGE_W = ADDR_WIDTH - IDX_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_wdata,
  input  logic                  cpu_we,
  output logic [REG_WIDTH-1:0]  cpu_rdata,
  output logic                  cpu_rdy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_din,
  output logic                  mem_we,
  input  logic [REG_WIDTH-1:0]  mem_dout,
  output logic [IDX_W-1:0]      oam_addr,
  output logic [REG_WIDTH-1:0]  oam_data,
  output logic                  oam_we,
  output logic                  dma_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              parity_q, parity_d;

  // State, source page, byte index and the free-running parity bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
    end
  end

  // Next-state decode and bus steering; mem belongs to the CPU only in IDLE.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    parity_d = ~parity_q;
    mem_addr = cpu_addr;
    mem_din  = cpu_wdata;
    mem_we   = 1'b0;
    oam_we   = 1'b0;
    oam_data = mem_dout;
    case (state_q)
      ST_IDLE: begin
        mem_we = cpu_we;
        if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
          // The trigger write itself is swallowed, not forwarded to mem.
          mem_we  = 1'b0;
          page_d  = cpu_wdata[PAGE_W-1:0];
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        // The 6502 ignores RDY during writes; wait until it is really stopped.
        if (!cpu_we) begin
          state_d = parity_q ? ST_ALIGN : ST_READ;
        end
      end
      ST_ALIGN: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        mem_addr = {page_q, idx_q};
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        oam_we = 1'b1;
        if (idx_q == IDX_W'(XFER_LEN - 1)) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cpu_rdata = mem_dout;
  assign cpu_rdy   = (state_q == ST_IDLE);
  assign dma_busy  = ~cpu_rdy;
  assign oam_addr  = idx_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a behavioural mem and OAM.
// Latency: checks trigger-to-first-write latency and total stall length.
// Backpressure: exercises CPU write held during HALT and reset mid-transfer.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;
  logic        dma_busy;

  oam_dma_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .oam_addr(oam_addr), .oam_data(oam_data), .oam_we(oam_we), .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural memory with one-cycle read latency.
  logic [7:0] mem [0:65535];
  int wr4014 = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      if (mem_addr == 16'h4014) wr4014 <= wr4014 + 1;
    end
    mem_dout <= mem[mem_addr];
  end

  // OAM model, cleared on request between transfers.
  logic clr = 1'b0;
  logic [7:0] oam [0:255];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) oam[i] <= 8'h00;
    end else if (oam_we) begin
      oam[oam_addr] <= oam_data;
    end
  end

  // Bench's own view of the parity bit: cycles since reset release, mod 2.
  logic par;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) par <= 1'b0;
    else          par <= ~par;
  end

  // Mid-cycle monitor: stall length, write pulses, first-write latency and address.
  int          stall_cnt = 0;
  int          oam_cnt = 0;
  int          memwe_busy = 0;
  int          memwe_idle = 0;
  int          first_we_at = 0;
  logic [15:0] first_rd_addr = 16'h0;
  logic [15:0] prev_addr = 16'h0;
  logic        seen_we = 1'b0;
  always @(negedge clk) begin
    if (clr) begin
      stall_cnt  <= 0;
      oam_cnt    <= 0;
      memwe_busy <= 0;
      memwe_idle <= 0;
      seen_we    <= 1'b0;
    end else begin
      if (!cpu_rdy) stall_cnt <= stall_cnt + 1;
      if (!cpu_rdy && mem_we) memwe_busy <= memwe_busy + 1;
      if (cpu_rdy && mem_we) memwe_idle <= memwe_idle + 1;
      if (oam_we) begin
        oam_cnt <= oam_cnt + 1;
        if (!seen_we) begin
          seen_we       <= 1'b1;
          first_we_at   <= stall_cnt + 1;
          first_rd_addr <= prev_addr;
        end
      end
    end
    prev_addr <= mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    tick();
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    tick();
    cpu_we    = 1'b0;
  endtask

  task automatic clr_stats();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Trigger in a cycle whose parity makes the HALT-exit parity odd (align=1) or even.
  task automatic trig(input logic [7:0] pg, input bit align, input int hold);
    tick();
    if (par != (align ? 1'b0 : 1'b1)) tick();
    cpu_addr  = 16'h4014;
    cpu_wdata = pg;
    cpu_we    = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      cpu_wdata = 8'h03;
    end
    tick();
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000; k++) begin
      if (cpu_rdy) break;
      tick();
    end
    chk("dma_complete", {31'd0, cpu_rdy}, 32'd1);
  endtask

  task automatic check_oam(input logic [7:0] key);
    logic [7:0] e;
    for (int i = 0; i < 256; i++) begin
      e = 8'(i) ^ key;
      chk("oam_byte", {24'd0, oam[i]}, {24'd0, e});
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    cpu_addr  = 16'h1234;
    cpu_wdata = 8'h00;
    cpu_we    = 1'b0;
    #1;
    chk("rst_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("rst_busy", {31'd0, dma_busy}, 32'd0);
    chk("rst_oam_we", {31'd0, oam_we}, 32'd0);
    chk("rst_oam_addr", {24'd0, oam_addr}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'h1234);
    tick();
    tick();
    reset_n = 1'b1;

    // Idle passthrough write and read-back.
    clr_stats();
    cpu_write(16'h0010, 8'h5A);
    tick();
    cpu_addr = 16'h0010;
    tick();
    chk("pass_rdata", {24'd0, cpu_rdata}, 32'h5A);
    chk("pass_mem_we_cnt", memwe_idle, 1);
    chk("pass_no_stall", stall_cnt, 0);

    // Source pages: 0x02 holds i^A5, 0xFF holds i^C3.
    for (int i = 0; i < 256; i++) cpu_write(16'h0200 | 16'(i), 8'(i) ^ 8'hA5);
    for (int i = 0; i < 256; i++) cpu_write(16'hFF00 | 16'(i), 8'(i) ^ 8'hC3);

    // Even parity: no ALIGN.
    clr_stats();
    trig(8'h02, 1'b0, 0);
    wait_done();
    chk("even_stall", stall_cnt, 513);
    chk("even_oam_cnt", oam_cnt, 256);
    chk("even_first_we", first_we_at, 3);
    chk("even_first_addr", {16'd0, first_rd_addr}, 32'h0200);
    chk("even_memwe_busy", memwe_busy, 0);
    check_oam(8'hA5);
    chk("reg_not_written", wr4014, 0);

    // Odd parity: one ALIGN cycle.
    clr_stats();
    trig(8'h02, 1'b1, 0);
    wait_done();
    chk("odd_stall", stall_cnt, 514);
    chk("odd_oam_cnt", oam_cnt, 256);
    chk("odd_first_we", first_we_at, 4);
    check_oam(8'hA5);

    // Write held three cycles into HALT, retriggering 0x4014 with page 3 (ignored).
    clr_stats();
    trig(8'h02, 1'b0, 3);
    wait_done();
    chk("hold_stall", stall_cnt, 517);
    chk("hold_first_we", first_we_at, 7);
    chk("hold_first_addr", {16'd0, first_rd_addr}, 32'h0200);
    chk("hold_memwe_busy", memwe_busy, 0);
    chk("hold_reg_not_written", wr4014, 0);
    check_oam(8'hA5);

    // Page 0xFF, reset after 100 OAM writes, then a full retrigger.
    clr_stats();
    trig(8'hFF, 1'b0, 0);
    for (int k = 0; k < 1000; k++) begin
      if (oam_cnt >= 100) break;
      tick();
    end
    chk("pre_reset_cnt", oam_cnt, 100);
    cpu_addr = 16'h0ABC;
    reset_n  = 1'b0;
    #1;
    chk("mid_rst_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("mid_rst_busy", {31'd0, dma_busy}, 32'd0);
    chk("mid_rst_oam_we", {31'd0, oam_we}, 32'd0);
    chk("mid_rst_idx", {24'd0, oam_addr}, 32'd0);
    chk("mid_rst_mem_addr", {16'd0, mem_addr}, 32'h0ABC);
    tick();
    tick();
    reset_n = 1'b1;
    chk("partial_byte98", {24'd0, oam[98]}, 32'(8'd98 ^ 8'hC3));
    chk("partial_byte99", {24'd0, oam[99]}, 32'h00);
    clr_stats();
    trig(8'hFF, 1'b0, 0);
    wait_done();
    chk("ff_stall", stall_cnt, 513);
    chk("ff_oam_cnt", oam_cnt, 256);
    chk("ff_first_addr", {16'd0, first_rd_addr}, 32'hFF00);
    check_oam(8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
